tone_sequencer: RTL
===================

Name: tone_sequencer

Overview:
Plays a stored sequence of scale-note selections in order, one after another. It drives the 3-bit note select and enable inputs of the scale-note decoder. Each note is held for a fixed on-time and followed by a fixed silent gap. Used in the Simon playback phase: game logic loads the pattern, pulses start, and waits for done.

Parameters:
ADDR_W, 5, sequence memory address width; DEPTH = 2**ADDR_W entries
NOTE_CYCLES, 25000000, clock cycles each note is enabled (>=1)
GAP_CYCLES, 5000000, clock cycles of silence after each note (>=1)
CNT_W, 25, width of the duration down-counter; must hold max(NOTE_CYCLES,GAP_CYCLES)-1

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
wr_en  in  1  write one sequence entry this cycle
wr_addr  in  ADDR_W  entry index to write
wr_data  in  3  note select value to store
length  in  ADDR_W+1  number of notes to play, sampled with start
start  in  1  begin playback (level sampled each cycle)
abort  in  1  stop playback immediately
busy  out  1  high while playing (PLAY or GAP)
done  out  1  one-cycle pulse on normal completion
note_sel  out  3  note select to decoder
note_en  out  1  decoder enable; high only during note on-time
cur_idx  out  ADDR_W  index of the note being played or gapped

Behaviour:
- Reset (async, no clock edge needed):
  - state=IDLE; busy=0, done=0, note_en=0, note_sel=0, cur_idx=0, counter=0, latched length=0.
  - All DEPTH memory entries clear to 3'b000.
- Memory: DEPTH x 3 flops, synchronous write.
  - wr_en is honoured only in IDLE and DONE; it is ignored while busy=1.
  - Reads are internal and combinational, by index.
- States: IDLE, PLAY, GAP, DONE. All outputs are registered.
- IDLE, start=1:
  - len_eff = min(length, DEPTH).
  - len_eff=0: go to DONE. done pulses next cycle; note_en never asserts.
  - Otherwise: latch len_eff, cur_idx=0, note_sel=mem[0], counter=NOTE_CYCLES-1, note_en=1, busy=1, go to PLAY.
- PLAY:
  - counter>0: decrement.
  - counter=0: note_en=0, counter=GAP_CYCLES-1, go to GAP.
  - note_sel holds its value through PLAY and GAP.
- GAP:
  - counter>0: decrement.
  - counter=0 and cur_idx=len_eff-1: busy=0, done=1, go to DONE.
  - counter=0 otherwise: cur_idx+1, note_sel=mem[cur_idx+1], counter=NOTE_CYCLES-1, note_en=1, go to PLAY.
- DONE: done=1 for exactly one cycle, then IDLE with done=0. start in DONE is ignored.
- Timing, start sampled at edge T:
  - note_en is high for cycles T+1..T+NOTE_CYCLES, then low for GAP_CYCLES, repeating per note.
  - busy is high for exactly len_eff*(NOTE_CYCLES+GAP_CYCLES) cycles.
  - done is high in the cycle right after busy falls.
- start while busy: ignored. length changes while busy: ignored (the latched value is used).
- abort (priority over everything except rst):
  - From PLAY or GAP, the next edge gives IDLE with busy=0, note_en=0, done=0, counter=0.
  - note_sel and cur_idx hold their values.
  - abort in IDLE or DONE: no effect, except that from DONE the block still returns to IDLE.
- abort and start in the same cycle in IDLE: abort wins and playback does not begin.
- Reset mid-playback: immediate return to reset values; memory contents are lost.
- Arithmetic:
  - The counter is unsigned CNT_W bits and never underflows; its transition is decided at 0.
  - cur_idx never exceeds len_eff-1, so there is no wrap.

Test Plan:
(All with ADDR_W=3, NOTE_CYCLES=4, GAP_CYCLES=2.)
1. Assert rst with no clock running -> busy, done, note_en, note_sel and cur_idx all 0 immediately.
2. Write mem[0]=3'b010, mem[1]=3'b111, mem[2]=3'b000; start with length=3.
   - note_en pattern: 4 high / 2 low, three times.
   - note_sel: 010, then 111, then 000. cur_idx: 0, 1, 2.
   - busy high for 18 cycles; done is a single pulse at cycle T+19.
3. start with length=0 -> done pulses at T+1; busy and note_en stay 0.
4. abort in the 2nd cycle of note index 1 -> next cycle busy=0, note_en=0, no done. A restart replays from index 0 with sel=010.
5. During playback, pulse start and write mem[0]=3'b101 -> no effect on playback or memory.
   - Afterwards, length=15 clamps to 8 notes: busy is 48 cycles, done follows at cycle 49.
6. Assert rst asynchronously mid-PLAY -> note_en=0 and busy=0 without a clock edge. A subsequent len=1 playback plays sel=000, since memory was cleared.

Source files
------------

// File: rtl/tone_sequencer.sv
// Plays a stored list of 3-bit note selections, each held for a fixed
// on-time followed by a fixed silent gap, then pulses done.
module tone_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int NOTE_CYCLES = 25000000,
    parameter int GAP_CYCLES  = 5000000,
    parameter int CNT_W       = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [2:0]        wr_data,
    input  logic [ADDR_W:0]   length,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [2:0]        note_sel,
    output logic              note_en,
    output logic [ADDR_W-1:0] cur_idx
);
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [CNT_W-1:0]  NOTE_LOAD = CNT_W'(NOTE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        GAP,
        DONE
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [2:0]        sel_q, sel_d;
    logic              en_q, en_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [2:0]        mem_q [DEPTH];

    logic [ADDR_W:0]   len_eff;
    logic [ADDR_W-1:0] idx_nxt;
    logic              last;

    assign len_eff = (length > DEPTH_L) ? DEPTH_L : length;
    assign idx_nxt = idx_q + ADDR_W'(1);
    assign last    = ({1'b0, idx_q} == (len_q - (ADDR_W + 1)'(1)));

    // Writes are locked out while a sequence is playing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 3'b000;
            end
        end else if (wr_en && (state_q == IDLE || state_q == DONE)) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            idx_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
            sel_q   <= sel_d;
            en_q    <= en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        idx_d   = idx_q;
        sel_d   = sel_q;
        en_d    = en_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (abort && (state_q == PLAY || state_q == GAP)) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            en_d    = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        if (len_eff == '0) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = PLAY;
                            len_d   = len_eff;
                            idx_d   = '0;
                            sel_d   = mem_q[0];
                            cnt_d   = NOTE_LOAD;
                            en_d    = 1'b1;
                            busy_d  = 1'b1;
                        end
                    end
                end
                PLAY: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        state_d = GAP;
                        en_d    = 1'b0;
                        cnt_d   = GAP_LOAD;
                    end
                end
                GAP: begin
                    if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else if (last) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = PLAY;
                        idx_d   = idx_nxt;
                        sel_d   = mem_q[idx_nxt];
                        cnt_d   = NOTE_LOAD;
                        en_d    = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign note_sel = sel_q;
    assign note_en  = en_q;
    assign cur_idx  = idx_q;
endmodule
